// File: rtl/lau_pkg.sv
// Shared types for the Log-Mel power stage: controller states, the buffered
// power beat and the kept-bin count helper.
package lau_pkg;

   typedef enum logic [1:0] {IDLE, KEEP, DROP} state_t;

   localparam int DEF_PW = 32;
   localparam int DEF_BW = 9;

   // Default-width beat; modules with overridden widths declare a matching local type.
   typedef struct packed {
      logic [DEF_PW-1:0] power;
      logic [DEF_BW-1:0] bin;
      logic              sof;
      logic              eof;
   } pwr_beat_t;

   function automatic int nbins(input int fft_size);
      return fft_size / 2 + 1;
   endfunction

endpackage

// File: rtl/power_calc.sv
// Squarer datapath: combinational (re^2 + im^2) >> SHIFT, valid delayed one cycle.
module power_calc #(
   parameter int IW    = 18,
   parameter int SHIFT = 6,
   parameter int PW    = 2*IW-SHIFT+2
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] real_il,
   input  logic [IW-1:0] imag_il,
   input  logic          valid_il,
   output logic [PW-1:0] power_ol,
   output logic          valid_ol
);

   logic signed [IW-1:0]   re_s, im_s;
   logic signed [2*IW-1:0] sq_re, sq_im;
   logic [2*IW:0]          sum;
   logic                   valid_q, valid_d;

   always_comb begin
      re_s     = $signed(real_il);
      im_s     = $signed(imag_il);
      sq_re    = re_s * re_s;
      sq_im    = im_s * im_s;
      sum      = {1'b0, sq_re} + {1'b0, sq_im};
      power_ol = PW'(sum >> SHIFT);
      valid_d  = valid_il;
   end

   always_ff @(posedge clk) begin
      if (rst) valid_q <= 1'b0;
      else     valid_q <= valid_d;
   end

   assign valid_ol = valid_q;

endmodule

// File: rtl/power_frame_ctrl_fifo.sv
// Synchronous FIFO of power beats with occupancy count; pop on empty is ignored.
module power_fifo
   import lau_pkg::*;
#(
   parameter type T      = pwr_beat_t,
   parameter int  DEPTH  = 4,
   localparam int AW     = $clog2(DEPTH)
)(
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  T        wdata,
   input  logic    pop,
   output T        rdata,
   output logic    empty,
   output logic [AW:0] count
);

   T              mem_q [DEPTH];
   T              mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !do_pop)      count_d = count_q + 1'b1;
      else if (!push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign count = count_q;

   push_on_full: assert property (@(posedge clk) disable iff (rst)
      !(push && count_q == (AW+1)'(DEPTH)));

endmodule

// File: rtl/power_frame_ctrl.sv
// Frame sequencer feeding power_calc: keeps bins 0..FFT_SIZE/2, drops mirrored
// bins, and buffers tagged power results in a credit-managed FIFO.
module power_frame_ctrl
   import lau_pkg::*;
#(
   parameter int  IW         = 18,
   parameter int  SHIFT      = 6,
   parameter int  PW         = 2*IW-SHIFT+2,
   parameter int  FFT_SIZE   = 512,
   parameter int  FIFO_DEPTH = 4,
   localparam int NBINS      = nbins(FFT_SIZE),
   localparam int BW         = $clog2(NBINS)
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            enable_il,
   input  logic [2*IW-1:0] fft_data_il,
   input  logic            fft_sof_il,
   input  logic            fft_valid_il,
   output logic            fft_ready_ol,
   output logic [IW-1:0]   pc_real_ol,
   output logic [IW-1:0]   pc_imag_ol,
   output logic            pc_valid_ol,
   input  logic [PW-1:0]   pc_power_il,
   input  logic            pc_valid_il,
   output logic [PW-1:0]   power_ol,
   output logic [BW-1:0]   bin_ol,
   output logic            sof_ol,
   output logic            eof_ol,
   output logic            valid_ol,
   input  logic            ready_il,
   output logic [15:0]     frame_cnt_ol,
   output logic            err_ol
);

   localparam int            FAW       = $clog2(FIFO_DEPTH);
   localparam logic [BW-1:0] LAST_KEEP = BW'(NBINS-1);
   localparam logic [BW-1:0] LAST_BIN  = BW'(FFT_SIZE-1);

   typedef struct packed {
      logic [PW-1:0] power;
      logic [BW-1:0] bin;
      logic          sof;
      logic          eof;
   } beat_t;

   state_t        state_q, state_d;
   logic [BW-1:0] bin_q, bin_d, pc_bin_q, pc_bin_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          err_q, err_d;
   logic [IW-1:0] pc_real_q, pc_real_d, pc_imag_q, pc_imag_d;
   logic          pc_valid_q, pc_valid_d, pcv_dly_q, pcv_dly_d;
   logic          credit, accept, resync, keep, keep_first;
   logic [FAW:0]  fifo_count;
   logic          fifo_empty;
   beat_t         push_beat, head;

   assign credit = (int'(fifo_count) + int'(pc_valid_q)) < FIFO_DEPTH;

   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      frame_cnt_d = frame_cnt_q;
      err_d       = err_q;
      pc_real_d   = pc_real_q;
      pc_imag_d   = pc_imag_q;
      pc_bin_d    = pc_bin_q;
      pcv_dly_d   = pc_valid_q;
      keep        = 1'b0;
      keep_first  = 1'b0;

      case (state_q)
         IDLE:    fft_ready_ol = enable_il && credit;
         KEEP:    fft_ready_ol = credit;
         default: fft_ready_ol = 1'b1;
      endcase
      accept = fft_valid_il && fft_ready_ol;
      resync = fft_sof_il && (bin_q != '0);

      if (accept) begin
         case (state_q)
            IDLE: begin
               if (fft_sof_il) begin
                  keep       = 1'b1;
                  keep_first = 1'b1;
                  bin_d      = BW'(1);
                  state_d    = KEEP;
               end else begin
                  err_d = 1'b1;
               end
            end
            KEEP: begin
               keep = 1'b1;
               if (resync) begin
                  err_d      = 1'b1;
                  keep_first = 1'b1;
                  bin_d      = BW'(1);
               end else begin
                  bin_d = bin_q + 1'b1;
                  if (bin_q == LAST_KEEP) state_d = DROP;
               end
            end
            DROP: begin
               if (resync) begin
                  err_d = 1'b1;
                  // DROP accepts without credit, so a resync beat that cannot be
                  // buffered is discarded and the stream waits in IDLE for the next sof.
                  if (credit) begin
                     keep       = 1'b1;
                     keep_first = 1'b1;
                     bin_d      = BW'(1);
                     state_d    = KEEP;
                  end else begin
                     bin_d   = '0;
                     state_d = IDLE;
                  end
               end else if (bin_q == LAST_BIN) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  bin_d       = '0;
                  state_d     = enable_il ? KEEP : IDLE;
               end else begin
                  bin_d = bin_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      pc_valid_d = keep;
      if (keep) begin
         pc_real_d = fft_data_il[2*IW-1:IW];
         pc_imag_d = fft_data_il[IW-1:0];
         pc_bin_d  = keep_first ? '0 : bin_q;
      end

      if (pc_valid_il != pcv_dly_q) err_d = 1'b1;

      push_beat.power = pc_power_il;
      push_beat.bin   = pc_bin_q;
      push_beat.sof   = (pc_bin_q == '0);
      push_beat.eof   = (pc_bin_q == LAST_KEEP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         frame_cnt_q <= '0;
         err_q       <= 1'b0;
         pc_real_q   <= '0;
         pc_imag_q   <= '0;
         pc_bin_q    <= '0;
         pc_valid_q  <= 1'b0;
         pcv_dly_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         frame_cnt_q <= frame_cnt_d;
         err_q       <= err_d;
         pc_real_q   <= pc_real_d;
         pc_imag_q   <= pc_imag_d;
         pc_bin_q    <= pc_bin_d;
         pc_valid_q  <= pc_valid_d;
         pcv_dly_q   <= pcv_dly_d;
      end
   end

   power_fifo #(
      .T     (beat_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pc_valid_q),
      .wdata (push_beat),
      .pop   (ready_il),
      .rdata (head),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign pc_real_ol   = pc_real_q;
   assign pc_imag_ol   = pc_imag_q;
   assign pc_valid_ol  = pc_valid_q;
   assign valid_ol     = !fifo_empty;
   assign power_ol     = head.power;
   assign bin_ol       = head.bin;
   assign sof_ol       = head.sof;
   assign eof_ol       = head.eof;
   assign frame_cnt_ol = frame_cnt_q;
   assign err_ol       = err_q;

endmodule

// File: tb/tb_power_frame_ctrl.sv
// Bench for power_frame_ctrl with power_calc at FFT_SIZE=8: directed frame
// scenarios plus a randomized stream checked against a frame-position model.
module tb_power_frame_ctrl;

   localparam int IW    = 18;
   localparam int SHIFT = 6;
   localparam int PW    = 32;
   localparam int FFT   = 8;
   localparam int NB    = FFT/2 + 1;
   localparam int BW    = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            enable_il = 1'b0;
   logic [2*IW-1:0] fft_data_il = '0;
   logic            fft_sof_il = 1'b0;
   logic            fft_valid_il = 1'b0;
   logic            fft_ready_ol;
   logic [IW-1:0]   pc_real, pc_imag;
   logic            pc_valid_o, pc_valid_i;
   logic [PW-1:0]   pc_power;
   logic [PW-1:0]   power_ol;
   logic [BW-1:0]   bin_ol;
   logic            sof_ol, eof_ol, valid_ol;
   logic            ready_il = 1'b0;
   logic [15:0]     frame_cnt_ol;
   logic            err_ol;

   int checks = 0;
   int errors = 0;
   int out_cnt = 0;
   int wait_cycles = 0;

   typedef struct {
      longint pwr;
      int     bin;
   } exp_t;

   exp_t exp_q[$];
   bit   m_in_frame = 0;
   int   m_pos = 0;
   bit   m_err = 0;
   int   m_frames = 0;

   always #5 clk = ~clk;

   power_frame_ctrl #(
      .IW         (IW),
      .SHIFT      (SHIFT),
      .PW         (PW),
      .FFT_SIZE   (FFT),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable_il    (enable_il),
      .fft_data_il  (fft_data_il),
      .fft_sof_il   (fft_sof_il),
      .fft_valid_il (fft_valid_il),
      .fft_ready_ol (fft_ready_ol),
      .pc_real_ol   (pc_real),
      .pc_imag_ol   (pc_imag),
      .pc_valid_ol  (pc_valid_o),
      .pc_power_il  (pc_power),
      .pc_valid_il  (pc_valid_i),
      .power_ol     (power_ol),
      .bin_ol       (bin_ol),
      .sof_ol       (sof_ol),
      .eof_ol       (eof_ol),
      .valid_ol     (valid_ol),
      .ready_il     (ready_il),
      .frame_cnt_ol (frame_cnt_ol),
      .err_ol       (err_ol)
   );

   power_calc #(
      .IW    (IW),
      .SHIFT (SHIFT),
      .PW    (PW)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .real_il  (pc_real),
      .imag_il  (pc_imag),
      .valid_il (pc_valid_o),
      .power_ol (pc_power),
      .valid_ol (pc_valid_i)
   );

   // Reference: a frame is a run of FFT beats starting at sof; the first NB are emitted.
   always @(negedge clk) begin
      logic signed [IW-1:0] re, im;
      exp_t e;
      if (rst) begin
         exp_q.delete();
         m_in_frame = 0;
         m_pos      = 0;
         m_err      = 0;
         m_frames   = 0;
      end else begin
         if (valid_ol && ready_il) begin
            checks++;
            out_cnt++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_unexpected: got bin=%0d power=%0d, expected no output", bin_ol, power_ol);
            end else begin
               e = exp_q.pop_front();
               if (power_ol !== 32'(e.pwr) || bin_ol !== 3'(e.bin) ||
                   sof_ol !== (e.bin == 0) || eof_ol !== (e.bin == NB-1)) begin
                  errors++;
                  $display("FAIL out_beat: got power=%0d bin=%0d sof=%0b eof=%0b, expected power=%0d bin=%0d sof=%0b eof=%0b",
                           power_ol, bin_ol, sof_ol, eof_ol, e.pwr, e.bin, e.bin == 0, e.bin == NB-1);
               end
            end
         end
         if (fft_valid_il && fft_ready_ol) begin
            re = fft_data_il[2*IW-1:IW];
            im = fft_data_il[IW-1:0];
            if (!m_in_frame) begin
               if (fft_sof_il) begin
                  m_in_frame = 1;
                  m_pos      = 0;
               end else begin
                  m_err = 1;
               end
            end else if (fft_sof_il && m_pos != 0) begin
               m_err = 1;
               m_pos = 0;
            end
            if (m_in_frame) begin
               if (m_pos < NB) begin
                  e.pwr = (longint'(re) * longint'(re) + longint'(im) * longint'(im)) >>> SHIFT;
                  e.bin = m_pos;
                  exp_q.push_back(e);
               end
               m_pos++;
               if (m_pos == FFT) begin
                  m_pos      = 0;
                  m_frames++;
                  m_in_frame = enable_il;
               end
            end
         end
      end
   end

   function automatic logic signed [IW-1:0] rnd();
      return IW'($urandom);
   endfunction

   task automatic send(input logic signed [IW-1:0] re, input logic signed [IW-1:0] im, input logic sof);
      bit acc = 0;
      int n   = 0;
      fft_data_il  = {re, im};
      fft_sof_il   = sof;
      fft_valid_il = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = fft_ready_ol;
         @(posedge clk);
         #1;
         n++;
      end
      fft_valid_il = 1'b0;
      fft_sof_il   = 1'b0;
      wait_cycles += n - 1;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no fft_ready_ol in %0d cycles, expected acceptance", n);
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      fft_valid_il = 1'b0;
      fft_sof_il   = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic wait_drain();
      ready_il = 1'b1;
      for (int i = 0; i < 100 && (exp_q.size() != 0 || valid_ol); i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      enable_il = 1'b0;
      ready_il  = 1'b1;
      do_reset();
      checks += 4;
      if (valid_ol !== 1'b0 || power_ol !== '0 || bin_ol !== '0 || sof_ol !== 1'b0 || eof_ol !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: got valid=%0b power=%0d bin=%0d sof=%0b eof=%0b, expected all 0",
                  valid_ol, power_ol, bin_ol, sof_ol, eof_ol);
      end
      if (fft_ready_ol !== 1'b0 || pc_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got ready=%0b pc_valid=%0b, expected 0 0", fft_ready_ol, pc_valid_o);
      end
      if (frame_cnt_ol !== 16'd0) begin
         errors++;
         $display("FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt_ol);
      end
      if (err_ol !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: got %0b, expected 0", err_ol);
      end
   endtask

   task automatic test_back_to_back();
      int oc;
      do_reset();
      enable_il   = 1'b1;
      ready_il    = 1'b1;
      oc          = out_cnt;
      wait_cycles = 0;
      for (int f = 0; f < 2; f++) begin
         send(18'sd100, 18'sd0, 1'b1);
         send(-18'sd128, 18'sd64, 1'b0);
         for (int b = 2; b < FFT; b++) send(rnd(), rnd(), 1'b0);
      end
      wait_drain();
      checks += 4;
      if (wait_cycles !== 0) begin
         errors++;
         $display("FAIL b2b_throughput: got %0d stall cycles, expected 0", wait_cycles);
      end
      if (out_cnt - oc !== 2*NB || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL b2b_count: got %0d outputs (%0d pending), expected %0d", out_cnt - oc, exp_q.size(), 2*NB);
      end
      if (frame_cnt_ol !== 16'd2) begin
         errors++;
         $display("FAIL b2b_frame_cnt: got %0d, expected 2", frame_cnt_ol);
      end
      if (err_ol !== 1'b0) begin
         errors++;
         $display("FAIL b2b_err: got %0b, expected 0", err_ol);
      end
   endtask

   task automatic test_backpressure();
      int  b = 0;
      int  acc_cnt = 0;
      int  oc;
      bit  acc;
      do_reset();
      enable_il    = 1'b1;
      ready_il     = 1'b0;
      oc           = out_cnt;
      fft_data_il  = {rnd(), rnd()};
      fft_sof_il   = 1'b1;
      fft_valid_il = 1'b1;
      repeat (10) begin
         @(negedge clk);
         acc = fft_ready_ol;
         @(posedge clk);
         #1;
         if (acc) begin
            acc_cnt++;
            b++;
            fft_data_il = {rnd(), rnd()};
            fft_sof_il  = 1'b0;
         end
      end
      checks += 2;
      if (acc_cnt !== 4) begin
         errors++;
         $display("FAIL bp_accepted: got %0d beats while stalled, expected 4", acc_cnt);
      end
      if (fft_ready_ol !== 1'b0) begin
         errors++;
         $display("FAIL bp_ready_low: got %0b, expected 0", fft_ready_ol);
      end
      fft_valid_il = 1'b0;
      ready_il     = 1'b1;
      for (; b < NB; b++) send(rnd(), rnd(), 1'b0);
      ready_il = 1'b0;
      for (; b < FFT; b++) begin
         fft_data_il  = {rnd(), rnd()};
         fft_valid_il = 1'b1;
         @(negedge clk);
         checks++;
         if (fft_ready_ol !== 1'b1) begin
            errors++;
            $display("FAIL bp_drop_ready: got %0b at bin %0d, expected 1", fft_ready_ol, b);
         end
         @(posedge clk);
         #1;
      end
      fft_valid_il = 1'b0;
      wait_drain();
      checks++;
      if (out_cnt - oc !== NB || exp_q.size() !== 0 || frame_cnt_ol !== 16'd1) begin
         errors++;
         $display("FAIL bp_stream: got %0d outputs pending=%0d frames=%0d, expected %0d 0 1",
                  out_cnt - oc, exp_q.size(), frame_cnt_ol, NB);
      end
   endtask

   task automatic test_resync();
      do_reset();
      enable_il = 1'b1;
      ready_il  = 1'b1;
      send(rnd(), rnd(), 1'b1);
      send(rnd(), rnd(), 1'b0);
      send(rnd(), rnd(), 1'b0);
      send(18'sd300, -18'sd200, 1'b1);
      checks += 2;
      if (err_ol !== 1'b1) begin
         errors++;
         $display("FAIL resync_err: got %0b, expected 1", err_ol);
      end
      if (frame_cnt_ol !== 16'd0) begin
         errors++;
         $display("FAIL resync_frame_cnt: got %0d, expected 0", frame_cnt_ol);
      end
      for (int b = 1; b < FFT; b++) send(rnd(), rnd(), 1'b0);
      wait_drain();
      checks++;
      if (frame_cnt_ol !== 16'd1 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL resync_done: got frames=%0d pending=%0d, expected 1 0", frame_cnt_ol, exp_q.size());
      end
   endtask

   task automatic test_idle();
      int acc_cnt = 0;
      int oc;
      do_reset();
      enable_il = 1'b1;
      ready_il  = 1'b1;
      oc        = out_cnt;
      send(18'sd5, 18'sd5, 1'b0);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      checks += 2;
      if (err_ol !== 1'b1) begin
         errors++;
         $display("FAIL idle_nosof_err: got %0b, expected 1", err_ol);
      end
      if (out_cnt !== oc || valid_ol !== 1'b0) begin
         errors++;
         $display("FAIL idle_nosof_drop: got %0d outputs valid=%0b, expected 0 0", out_cnt - oc, valid_ol);
      end
      send(rnd(), rnd(), 1'b1);
      for (int b = 1; b < FFT-1; b++) send(rnd(), rnd(), 1'b0);
      enable_il = 1'b0;
      send(rnd(), rnd(), 1'b0);
      fft_data_il  = {rnd(), rnd()};
      fft_sof_il   = 1'b1;
      fft_valid_il = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (fft_ready_ol) acc_cnt++;
         @(posedge clk);
         #1;
      end
      checks += 2;
      if (acc_cnt !== 0) begin
         errors++;
         $display("FAIL idle_disabled_ready: got %0d accepts, expected 0", acc_cnt);
      end
      if (frame_cnt_ol !== 16'd1) begin
         errors++;
         $display("FAIL idle_frame_cnt: got %0d, expected 1", frame_cnt_ol);
      end
      enable_il = 1'b1;
      @(negedge clk);
      checks++;
      if (fft_ready_ol !== 1'b1) begin
         errors++;
         $display("FAIL idle_reenable_ready: got %0b, expected 1", fft_ready_ol);
      end
      @(posedge clk);
      #1;
      fft_valid_il = 1'b0;
      fft_sof_il   = 1'b0;
      for (int b = 1; b < FFT; b++) send(rnd(), rnd(), 1'b0);
      wait_drain();
      checks++;
      if (frame_cnt_ol !== 16'd2 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL idle_resume: got frames=%0d pending=%0d, expected 2 0", frame_cnt_ol, exp_q.size());
      end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      enable_il = 1'b1;
      ready_il  = 1'b0;
      send(rnd(), rnd(), 1'b1);
      send(rnd(), rnd(), 1'b0);
      send(rnd(), rnd(), 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks += 2;
      if (valid_ol !== 1'b0 || pc_valid_o !== 1'b0 || bin_ol !== '0) begin
         errors++;
         $display("FAIL rstmid_flush: got valid=%0b pc_valid=%0b bin=%0d, expected 0 0 0", valid_ol, pc_valid_o, bin_ol);
      end
      if (fft_ready_ol !== 1'b1 || frame_cnt_ol !== 16'd0) begin
         errors++;
         $display("FAIL rstmid_idle: got ready=%0b frames=%0d, expected 1 0", fft_ready_ol, frame_cnt_ol);
      end
      send(18'sd100, 18'sd0, 1'b1);
      checks++;
      if (valid_ol !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: got valid=%0b one cycle after accept, expected 0", valid_ol);
      end
      @(posedge clk);
      #1;
      checks++;
      if (valid_ol !== 1'b1 || power_ol !== 32'd156 || bin_ol !== 3'd0 || sof_ol !== 1'b1 || eof_ol !== 1'b0) begin
         errors++;
         $display("FAIL latency_bin0: got valid=%0b power=%0d bin=%0d sof=%0b eof=%0b, expected 1 156 0 1 0",
                  valid_ol, power_ol, bin_ol, sof_ol, eof_ol);
      end
      send(-18'sd128, 18'sd64, 1'b0);
      @(posedge clk);
      #1;
      ready_il = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (valid_ol !== 1'b1 || power_ol !== 32'd320 || bin_ol !== 3'd1 || sof_ol !== 1'b0) begin
         errors++;
         $display("FAIL bin1_power: got valid=%0b power=%0d bin=%0d sof=%0b, expected 1 320 1 0",
                  valid_ol, power_ol, bin_ol, sof_ol);
      end
      for (int b = 2; b < FFT; b++) send(rnd(), rnd(), 1'b0);
      wait_drain();
      checks++;
      if (frame_cnt_ol !== 16'd1 || err_ol !== 1'b0 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL rstmid_frame: got frames=%0d err=%0b pending=%0d, expected 1 0 0",
                  frame_cnt_ol, err_ol, exp_q.size());
      end
   endtask

   task automatic test_random();
      bit done = 0;
      do_reset();
      enable_il = 1'b1;
      fork
         begin
            for (int f = 0; f < 100; f++) begin
               for (int b = 0; b < FFT; b++) begin
                  if ($urandom_range(0, 3) == 0) begin
                     repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                     end
                  end
                  send(rnd(), rnd(), (b == 0));
               end
            end
            done = 1;
         end
         begin
            while (!done) begin
               ready_il = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      wait_drain();
      checks += 2;
      if (frame_cnt_ol !== 16'(m_frames) || m_frames !== 100) begin
         errors++;
         $display("FAIL rand_frames: got %0d, expected %0d (model %0d)", frame_cnt_ol, 100, m_frames);
      end
      if (err_ol !== 1'b0 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL rand_clean: got err=%0b pending=%0d, expected 0 0", err_ol, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_resync();
      test_idle();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/power_frame_ctrl.md
Name: power_frame_ctrl

Overview:
Frame-level sequencer for the squarer/power datapath (power_calc) in the Log-Mel front end. It accepts the STFT output stream with a valid/ready handshake and tracks bin position within each FFT frame. It forwards only the non-redundant bins 0..FFT_SIZE/2 to power_calc and discards the mirrored bins. Results are buffered in a small credit-managed FIFO and emitted downstream with bin index and start/end-of-frame tags, so the power datapath never needs backpressure.

Parameters:
IW, 18, real/imag component width from STFT
SHIFT, 6, LSBs dropped by power_calc
PW, 2*IW-SHIFT+2, power word width (32 at defaults)
FFT_SIZE, 512, bins per frame; power of two, >= 8
NBINS, FFT_SIZE/2+1, kept bins per frame (derived; not overridable)
FIFO_DEPTH, 4, output buffer entries; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable_il  in  1  allow new frames to start
fft_data_il  in  2*IW  {real[2*IW-1:IW], imag[IW-1:0]}, signed
fft_sof_il  in  1  marks bin 0 of a frame
fft_valid_il  in  1  input beat valid
fft_ready_ol  out  1  input beat accepted when valid&ready
pc_real_ol  out  IW  to power_calc real_il
pc_imag_ol  out  IW  to power_calc imag_il
pc_valid_ol  out  1  to power_calc valid_il
pc_power_il  in  PW  from power_calc power_ol
pc_valid_il  in  1  from power_calc valid_ol (checked only)
power_ol  out  PW  power of current output bin
bin_ol  out  $clog2(NBINS)  bin index 0..NBINS-1
sof_ol  out  1  bin_ol==0
eof_ol  out  1  bin_ol==NBINS-1
valid_ol  out  1  output valid
ready_il  in  1  downstream ready
frame_cnt_ol  out  16  completed frames, wraps at 2^16
err_ol  out  1  sticky protocol error

Behaviour:
- Reset values: all outputs 0; FIFO empty; bin counter 0; state IDLE; err_ol cleared only by rst.
- Bin counter: advances on every accepted beat, 0..FFT_SIZE-1, and wraps to 0.
- State machine:
  - IDLE: ready only if enable_il and credit. The first accepted beat must carry fft_sof_il. A beat without sof is consumed and dropped, sets err_ol, and the state stays IDLE. An accepted beat with sof is treated as bin 0: kept, state -> KEEP.
  - KEEP: bins 0..NBINS-1 are kept. Ready requires credit. After bin NBINS-1 is accepted -> DROP.
  - DROP: fft_ready_ol=1 unconditionally; beats are consumed and not forwarded. After bin FFT_SIZE-1 is accepted: frame_cnt_ol+1, then -> KEEP if enable_il, else IDLE.
- enable_il is ignored in KEEP and DROP; frames always complete.
- Resync: in KEEP or DROP, an accepted beat with fft_sof_il at bin != 0 sets err_ol. The counter restarts with that beat as bin 0 in KEEP, and frame_cnt_ol is not incremented.
- Credit: credit = FIFO_DEPTH - fifo_count - pc_valid_ol > 0. Same-cycle pop is not counted.
- Issue:
  - A kept beat accepted at edge k gives pc_real/imag/valid registered high in cycle k+1.
  - pc_valid_ol is low on cycles with no issue; pc_real/imag hold their last value.
  - power_calc is combinational on data. pc_power_il is captured into the FIFO at the end of the cycle where pc_valid_ol=1, together with the bin index and sof/eof tags.
- Check: pc_valid_il must equal pc_valid_ol delayed one cycle. A mismatch sets err_ol.
- Output: valid_ol = FIFO non-empty; power/bin/sof/eof come from the FIFO head; pop on valid_ol&ready_il.
- FIFO behaviour:
  - Simultaneous push and pop is legal at any count.
  - Overflow is impossible by credit. A push on full is a design bug and is covered by an assertion.
- Latency and throughput:
  - Accepted input to valid_ol is 2 cycles when the FIFO is empty.
  - Sustains 1 bin/cycle with ready_il held high.
  - Downstream stalls backpressure the input within FIFO_DEPTH beats.
- rst mid-frame: all state is discarded immediately and the next cycle is IDLE. In-flight and buffered results are lost.

Decomposition:
- The shared package lau_pkg holds:
  - typedef enum state_t {IDLE, KEEP, DROP}
  - a struct pwr_beat_t {power, bin, sof, eof}
  - a function nbins(fft_size)
- One natural sub-module is power_fifo: synchronous FIFO of pwr_beat_t with count output. The controller, credit logic and error checks stay in power_frame_ctrl.
- The bench instantiates power_frame_ctrl together with the real power_calc.

Test Plan:
1. FFT_SIZE=8, enable_il=1, two back-to-back frames (sof on beat 0 only), ready_il=1: bin0 real=100 imag=0 -> power_ol=156 (10000>>6), bin_ol=0, sof_ol=1. bin1 real=-128 imag=64 -> power 320. Exactly bins 0..4 are emitted per frame (eof on bin 4), beats 5..7 are dropped. frame_cnt_ol=2 and err_ol=0 after the run.
2. Backpressure: ready_il=0 for 10 cycles mid-KEEP -> fft_ready_ol falls after 4 beats. No output is lost or duplicated. In DROP, fft_ready_ol stays 1 even with ready_il=0.
3. sof asserted at bin 3 in KEEP -> err_ol=1. The next output is bin_ol=0 carrying that beat's power, and frame_cnt_ol is unchanged.
4. In IDLE, a beat without sof is dropped and err_ol=1. enable_il=0 at frame end -> IDLE with fft_ready_ol=0 until enable_il returns.
5. rst asserted while the FIFO holds 3 entries mid-frame -> next cycle valid_ol=0, bin counter=0, IDLE. A new sof beat yields bin_ol=0 output 2 cycles after acceptance.
6. Random valid/ready toggling over 100 frames against a model -> outputs match square-sum>>SHIFT, in order, tags correct.
